// File: rtl/barcode_fifo.sv
// Range-checked capture FIFO for scanned barcode words {product, month, day}.
// Valid/acknowledge read side; rejected and overflowed codes are counted and flagged.
module barcode_fifo #(
  parameter int unsigned DAY_W  = 5,
  parameter int unsigned MON_W  = 4,
  parameter int unsigned PROD_W = 3,
  parameter int unsigned DEPTH  = 4,
  parameter int unsigned ERR_W  = 8,
  localparam int unsigned W     = DAY_W + MON_W + PROD_W,
  localparam int unsigned AW    = $clog2(DEPTH),
  localparam int unsigned CW    = $clog2(DEPTH) + 1
) (
  input  logic             CLK,
  input  logic             CLR,
  input  logic             EN,
  input  logic [W-1:0]     L,
  input  logic             LD,
  output logic             RDY_IN,
  output logic [W-1:0]     QR,
  output logic             VAL,
  input  logic             ACK,
  output logic [CW-1:0]    CNT,
  output logic [ERR_W-1:0] ERR_CNT,
  output logic             REJ
);

  logic [W-1:0]     r_mem [DEPTH];
  logic [W-1:0]     r_hold;
  logic [AW-1:0]    r_wr_ptr;
  logic [AW-1:0]    r_rd_ptr;
  logic [CW-1:0]    r_cnt;
  logic [ERR_W-1:0] r_err;
  logic             r_rej;

  logic [DAY_W-1:0] w_day;
  logic [MON_W-1:0] w_mon;
  logic             w_valid;
  logic             w_full;
  logic             w_empty;
  logic             w_pop;
  logic             w_push;
  logic             w_rej;

  assign w_day   = L[DAY_W-1:0];
  assign w_mon   = L[DAY_W+MON_W-1:DAY_W];
  assign w_valid = (w_day != '0) && (32'(w_day) <= 32'd31) &&
                   (w_mon != '0) && (32'(w_mon) <= 32'd12);

  assign w_full  = (r_cnt == CW'(DEPTH));
  assign w_empty = (r_cnt == '0);
  assign w_pop   = EN & ACK & ~w_empty;
  // A full FIFO still accepts a code when the head leaves on the same edge.
  assign w_push  = EN & LD & w_valid & (~w_full | w_pop);
  assign w_rej   = EN & LD & (~w_valid | (w_full & ~w_pop));

  always_ff @(posedge CLK or negedge CLR) begin
    if (!CLR) begin
      for (int i = 0; i < int'(DEPTH); i++) begin
        r_mem[i] <= '0;
      end
      r_hold   <= '0;
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_cnt    <= '0;
      r_err    <= '0;
      r_rej    <= 1'b0;
    end else begin
      r_rej <= w_rej;
      if (w_push) begin
        r_mem[r_wr_ptr] <= L;
        r_wr_ptr        <= r_wr_ptr + AW'(1);
      end
      if (w_pop) begin
        r_hold   <= r_mem[r_rd_ptr];
        r_rd_ptr <= r_rd_ptr + AW'(1);
      end
      case ({w_push, w_pop})
        2'b10:   r_cnt <= r_cnt + CW'(1);
        2'b01:   r_cnt <= r_cnt - CW'(1);
        default: r_cnt <= r_cnt;
      endcase
      if (w_rej && (r_err != '1)) begin
        r_err <= r_err + ERR_W'(1);
      end
    end
  end

  // Once drained, the read slot may hold stale data, so show the last popped code instead.
  assign QR      = w_empty ? r_hold : r_mem[r_rd_ptr];
  assign VAL     = ~w_empty;
  assign RDY_IN  = ~w_full;
  assign CNT     = r_cnt;
  assign ERR_CNT = r_err;
  assign REJ     = r_rej;

endmodule

// File: tb/tb_barcode_fifo.sv
// Self-checking bench for barcode_fifo: directed scenarios plus randomized traffic
// compared against a queue-based reference model.
module tb_barcode_fifo;

  localparam int DEPTH = 4;
  localparam int W     = 12;
  localparam int CW    = 3;
  localparam int ERR_W = 8;
  localparam int ERR_MAX = 255;

  logic             CLK = 1'b0;
  logic             CLR;
  logic             EN;
  logic [W-1:0]     L;
  logic             LD;
  logic             RDY_IN;
  logic [W-1:0]     QR;
  logic             VAL;
  logic             ACK;
  logic [CW-1:0]    CNT;
  logic [ERR_W-1:0] ERR_CNT;
  logic             REJ;

  int checks = 0;
  int errors = 0;

  // Reference model state
  logic [W-1:0] m_q [$];
  logic [W-1:0] m_last;
  int           m_err;
  logic         m_rej;

  barcode_fifo #(
    .DAY_W (5),
    .MON_W (4),
    .PROD_W(3),
    .DEPTH (DEPTH),
    .ERR_W (ERR_W)
  ) dut (
    .CLK    (CLK),
    .CLR    (CLR),
    .EN     (EN),
    .L      (L),
    .LD     (LD),
    .RDY_IN (RDY_IN),
    .QR     (QR),
    .VAL    (VAL),
    .ACK    (ACK),
    .CNT    (CNT),
    .ERR_CNT(ERR_CNT),
    .REJ    (REJ)
  );

  always #5 CLK = ~CLK;

  function automatic logic code_ok(input logic [W-1:0] l);
    int d, m;
    d = int'(l) % 32;
    m = (int'(l) / 32) % 16;
    return (d >= 1 && d <= 31 && m >= 1 && m <= 12);
  endfunction

  function automatic logic [W-1:0] exp_qr();
    return (m_q.size() > 0) ? m_q[0] : m_last;
  endfunction

  task automatic model_reset();
    m_q.delete();
    m_last = '0;
    m_err  = 0;
    m_rej  = 1'b0;
  endtask

  // Drive one cycle of inputs, advance the model, land 1 time unit after the edge.
  task automatic step(input logic en, input logic ld, input logic ack, input logic [W-1:0] l);
    logic pop, full, ok, rej;
    EN = en; LD = ld; ACK = ack; L = l;
    ok   = code_ok(l);
    full = (m_q.size() == DEPTH);
    pop  = en && ack && (m_q.size() > 0);
    rej  = en && ld && (!ok || (full && !pop));
    if (pop) m_last = m_q.pop_front();
    if (en && ld && ok && (!full || pop)) m_q.push_back(l);
    m_rej = rej;
    if (rej && m_err < ERR_MAX) m_err++;
    @(posedge CLK);
    #1;
  endtask

  task automatic apply_reset();
    EN = 1'b1; LD = 1'b0; ACK = 1'b0; L = '0;
    @(negedge CLK);
    CLR = 1'b0;
    model_reset();
    @(negedge CLK);
    CLR = 1'b1;
    @(posedge CLK);
    #1;
  endtask

  task automatic test_reset();
    #3;
    checks += 6;
    if (CNT !== 0)    begin errors++; $display("FAIL reset_cnt: got %0d expected 0", CNT); end
    if (VAL !== 0)    begin errors++; $display("FAIL reset_val: got %b expected 0", VAL); end
    if (RDY_IN !== 1) begin errors++; $display("FAIL reset_rdy: got %b expected 1", RDY_IN); end
    if (QR !== 0)     begin errors++; $display("FAIL reset_qr: got %h expected 0", QR); end
    if (ERR_CNT !== 0) begin errors++; $display("FAIL reset_err: got %0d expected 0", ERR_CNT); end
    if (REJ !== 0)    begin errors++; $display("FAIL reset_rej: got %b expected 0", REJ); end
    @(negedge CLK);
    CLR = 1'b1;
    @(posedge CLK);
    #1;
  endtask

  task automatic test_single();
    step(1, 1, 0, 12'hA4E);
    checks += 3;
    if (VAL !== 1)       begin errors++; $display("FAIL single_val: got %b expected 1", VAL); end
    if (QR !== 12'hA4E)  begin errors++; $display("FAIL single_qr: got %h expected a4e", QR); end
    if (CNT !== 1)       begin errors++; $display("FAIL single_cnt: got %0d expected 1", CNT); end
    step(1, 0, 1, '0);
    checks += 3;
    if (VAL !== 0)       begin errors++; $display("FAIL pop_val: got %b expected 0", VAL); end
    if (CNT !== 0)       begin errors++; $display("FAIL pop_cnt: got %0d expected 0", CNT); end
    if (QR !== exp_qr()) begin errors++; $display("FAIL pop_hold_qr: got %h expected %h", QR, exp_qr()); end
  endtask

  task automatic test_invalid();
    step(1, 1, 0, 12'hBAE);
    checks += 2;
    if (REJ !== 1) begin errors++; $display("FAIL inv_month_rej: got %b expected 1", REJ); end
    if (CNT !== 0) begin errors++; $display("FAIL inv_month_cnt: got %0d expected 0", CNT); end
    step(1, 1, 0, 12'hA40);
    checks += 3;
    if (REJ !== 1)     begin errors++; $display("FAIL inv_day_rej: got %b expected 1", REJ); end
    if (CNT !== 0)     begin errors++; $display("FAIL inv_day_cnt: got %0d expected 0", CNT); end
    if (ERR_CNT !== 2) begin errors++; $display("FAIL inv_err: got %0d expected 2", ERR_CNT); end
    step(1, 0, 0, '0);
    checks++;
    if (REJ !== 0) begin errors++; $display("FAIL inv_rej_pulse: got %b expected 0", REJ); end
  endtask

  task automatic test_fill_overflow();
    logic [W-1:0] order [4] = '{12'hA41, 12'hA42, 12'hA43, 12'hA44};
    for (int i = 0; i < 4; i++) step(1, 1, 0, order[i]);
    checks += 2;
    if (CNT !== 4)    begin errors++; $display("FAIL fill_cnt: got %0d expected 4", CNT); end
    if (RDY_IN !== 0) begin errors++; $display("FAIL fill_rdy: got %b expected 0", RDY_IN); end
    step(1, 1, 0, 12'hA45);
    checks += 3;
    if (REJ !== 1)     begin errors++; $display("FAIL ovf_rej: got %b expected 1", REJ); end
    if (ERR_CNT !== 3) begin errors++; $display("FAIL ovf_err: got %0d expected 3", ERR_CNT); end
    if (CNT !== 4)     begin errors++; $display("FAIL ovf_cnt: got %0d expected 4", CNT); end
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (QR !== order[i]) begin errors++; $display("FAIL drain_order%0d: got %h expected %h", i, QR, order[i]); end
      step(1, 0, 1, '0);
    end
    checks++;
    if (VAL !== 0) begin errors++; $display("FAIL drain_val: got %b expected 0", VAL); end
  endtask

  task automatic test_full_push_pop();
    logic [W-1:0] order [4] = '{12'hA42, 12'hA43, 12'hA44, 12'hA45};
    for (int i = 1; i <= 4; i++) step(1, 1, 0, 12'hA40 + W'(i));
    step(1, 1, 1, 12'hA45);
    checks += 3;
    if (CNT !== 4)       begin errors++; $display("FAIL fpp_cnt: got %0d expected 4", CNT); end
    if (REJ !== 0)       begin errors++; $display("FAIL fpp_rej: got %b expected 0", REJ); end
    if (QR !== 12'hA42)  begin errors++; $display("FAIL fpp_head: got %h expected a42", QR); end
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (QR !== order[i]) begin errors++; $display("FAIL fpp_order%0d: got %h expected %h", i, QR, order[i]); end
      step(1, 0, 1, '0);
    end
  endtask

  task automatic test_enable_and_reset();
    logic [W-1:0] qr_before;
    logic [ERR_W-1:0] err_before;
    for (int i = 6; i <= 8; i++) step(1, 1, 0, 12'hA40 + W'(i));
    qr_before  = QR;
    err_before = ERR_CNT;
    step(0, 1, 1, 12'hA49);
    checks += 4;
    if (CNT !== 3)            begin errors++; $display("FAIL en_cnt: got %0d expected 3", CNT); end
    if (QR !== qr_before)     begin errors++; $display("FAIL en_qr: got %h expected %h", QR, qr_before); end
    if (ERR_CNT !== err_before) begin errors++; $display("FAIL en_err: got %0d expected %0d", ERR_CNT, err_before); end
    if (REJ !== 0)            begin errors++; $display("FAIL en_rej: got %b expected 0", REJ); end
    EN = 1'b1; LD = 1'b0; ACK = 1'b0;
    #2;
    CLR = 1'b0;
    model_reset();
    #1;
    checks += 4;
    if (CNT !== 0)     begin errors++; $display("FAIL async_cnt: got %0d expected 0", CNT); end
    if (VAL !== 0)     begin errors++; $display("FAIL async_val: got %b expected 0", VAL); end
    if (QR !== 0)      begin errors++; $display("FAIL async_qr: got %h expected 0", QR); end
    if (ERR_CNT !== 0) begin errors++; $display("FAIL async_err: got %0d expected 0", ERR_CNT); end
    @(negedge CLK);
    CLR = 1'b1;
    @(posedge CLK);
    #1;
  endtask

  task automatic test_saturation();
    logic [W-1:0] l;
    logic [3:0]   mon;
    for (int i = 0; i < 260; i++) begin
      mon = (i % 2 == 0) ? 4'd0 : 4'(13 + (i % 3));
      l   = {3'($urandom_range(0, 7)), mon, 5'($urandom_range(0, 31))};
      step(1, 1, 0, l);
      checks++;
      if (REJ !== 1) begin errors++; $display("FAIL sat_rej%0d: got %b expected 1", i, REJ); end
    end
    checks++;
    if (ERR_CNT !== ERR_W'(ERR_MAX)) begin
      errors++; $display("FAIL sat_err: got %0d expected %0d", ERR_CNT, ERR_MAX);
    end
  endtask

  task automatic test_random();
    logic en, ld, ack;
    logic [W-1:0] l;
    apply_reset();
    for (int i = 0; i < 400; i++) begin
      en  = ($urandom_range(0, 9) != 0);
      ld  = ($urandom_range(0, 2) != 0);
      ack = ($urandom_range(0, 2) == 0) || (i > 300 && $urandom_range(0, 1) == 1);
      l   = W'($urandom_range(0, 4095));
      step(en, ld, ack, l);
      checks += 5;
      if (CNT !== CW'(m_q.size()))  begin errors++; $display("FAIL rnd_cnt%0d: got %0d expected %0d", i, CNT, m_q.size()); end
      if (VAL !== (m_q.size() != 0)) begin errors++; $display("FAIL rnd_val%0d: got %b", i, VAL); end
      if (QR !== exp_qr())          begin errors++; $display("FAIL rnd_qr%0d: got %h expected %h", i, QR, exp_qr()); end
      if (ERR_CNT !== ERR_W'(m_err)) begin errors++; $display("FAIL rnd_err%0d: got %0d expected %0d", i, ERR_CNT, m_err); end
      if (REJ !== m_rej)            begin errors++; $display("FAIL rnd_rej%0d: got %b expected %b", i, REJ, m_rej); end
    end
  endtask

  initial begin
    CLR = 1'b0; EN = 1'b1; LD = 1'b0; ACK = 1'b0; L = '0;
    model_reset();
    test_reset();
    test_single();
    test_invalid();
    test_fill_overflow();
    test_full_push_pop();
    test_enable_and_reset();
    test_saturation();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/barcode_fifo.md
# barcode_fifo

Parametrised capture buffer for scanned barcode words (day, month, product code). It sits between the barcode input and the downstream decode/compare logic, and replaces the single holding register with a DEPTH-entry FIFO. Each incoming code is range-checked before it is stored. Downstream reads use a valid/acknowledge handshake, and rejected or overflowed codes are counted.

## Interface
- DAY_W, 5, day field width (L[DAY_W-1:0])
- MON_W, 4, month field width (L[DAY_W+MON_W-1:DAY_W])
- PROD_W, 3, product-code field width (top PROD_W bits of L)
- DEPTH, 4, number of entries; power of two, ≥2
- ERR_W, 8, width of saturating error counter
- W (derived) = DAY_W+MON_W+PROD_W; CW (derived) = clog2(DEPTH)+1

Ports:
- CLK  in  1  clock, all state updates on rising edge
- CLR  in  1  one clock; reset is asynchronous and active-low
- EN  in  1  global enable; low freezes all state
- L  in  W  barcode word {product, month, day}
- LD  in  1  load strobe, sampled on rising CLK
- RDY_IN  out  1  high when FIFO not full
- QR  out  W  head entry (oldest stored code)
- VAL  out  1  high when FIFO not empty; QR valid
- ACK  in  1  consumer pops head when VAL & ACK at rising CLK
- CNT  out  CW  number of stored entries, 0..DEPTH
- ERR_CNT  out  ERR_W  rejected+overflowed codes, saturates at all-ones
- REJ  out  1  one-cycle pulse: code on this edge was rejected or dropped

## Operation
- Field check (combinational on L): valid iff day ∈ [1,31] and month ∈ [1,12]. Product field is unchecked.
- All actions below require EN=1. With EN=0 there is no push, no pop, no counter change, and REJ=0.
- push = LD & valid & (CNT<DEPTH | pop). A code is written at the write pointer, and the write pointer advances mod DEPTH.
- pop = ACK & VAL. The read pointer advances mod DEPTH. ACK with VAL=0 is ignored.
- Simultaneous push+pop:
  - CNT is unchanged.
  - When full, a push with pop is accepted, because the popped slot is freed on the same edge.
  - When empty, only the push happens, since pop requires VAL.
- Reject conditions, each giving a REJ pulse on the next cycle and ERR_CNT+1 (saturating):
  - LD & !valid, which is never stored;
  - LD & valid & full & !pop, an overflow where the code is dropped and the FIFO is unchanged.
- QR = mem[rd_ptr] (registered array, combinational read mux). QR holds its last value when empty.
- RDY_IN = (CNT<DEPTH); VAL = (CNT≠0). Both derive from the registered CNT.
- Pointers are clog2(DEPTH) bits and wrap naturally. CNT is the authoritative full/empty indicator.

## Timing
- Reset (CLR=0, asynchronous, immediate):
  - pointers=0, CNT=0, all entries=0;
  - QR=0, VAL=0, RDY_IN=1, ERR_CNT=0, REJ=0.
- Reset is held until CLR rises. The first possible push is on the first rising CLK with CLR=1.
- Reset mid-operation discards all entries and the error count with no partial updates.
- Push latency: a code accepted on edge n appears on QR with VAL=1 after edge n (cycle n+1) if the FIFO was empty. Otherwise it appears once all older entries have popped.
- Pop: after the edge with VAL&ACK, QR shows the next entry (or holds, with VAL=0, if the FIFO became empty).
- Back-to-back pushes every cycle until full. The consumer may hold ACK=1 continuously for one pop per cycle.
- REJ is registered: high for exactly the one cycle after the offending edge.
- ERR_CNT at all-ones stays there, while REJ still pulses.

## Test plan
- Reset, then LD=1 with L=0xA4E (prod 5, month 2, day 14) for one cycle -> next cycle VAL=1, QR=0xA4E, CNT=1. ACK=1 for one cycle -> VAL=0, CNT=0, QR still 0xA4E.
- Invalid codes: L=0xBAE (month 13) then L=0xA40 (day 0) -> nothing stored, CNT=0, REJ pulses twice, ERR_CNT=2.
- Fill and overflow: push 0xA41..0xA44 (DEPTH=4) -> CNT=4, RDY_IN=0. Push 0xA45 with ACK=0 -> dropped, ERR_CNT+1. Pop four times -> QR order 0xA41,0xA42,0xA43,0xA44.
- Full with simultaneous LD=1 (0xA45) and ACK=1 -> CNT stays 4, no REJ. Head becomes 0xA42 and 0xA45 is the last entry. This also exercises pointer wrap after more than DEPTH pushes.
- EN=0 with LD=1 and ACK=1 on valid data -> CNT, QR and ERR_CNT unchanged, REJ=0. Then assert CLR=0 asynchronously mid-cycle with CNT=3 -> immediately CNT=0, VAL=0, QR=0, ERR_CNT=0.
- ERR_CNT saturation: 260 invalid loads with ERR_W=8 -> ERR_CNT=255, REJ still pulses on each.
